// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Holds a host-loaded program store and walks it with a program counter,
//   handing one 16-bit instruction at a time to the CPU core over a
//   valid/ready handshake. HALT (0xF) and JUMP (0xE) words are executed here
//   and never reach the core.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   load_en/addr/data   host write port into the program store (IDLE/HALT only)
//   start, start_addr   begin execution at start_addr (ignored while busy)
//   abort               return to IDLE from any state
//   step_mode, step     single-step: wait for step after each accepted instr
//   instr, instr_valid  instruction to the core; instr_ready accepts it
//   pc                  current program counter
//   busy                high in FETCH, DECODE, ISSUE, WAIT_STEP
//   halted              a HALT word was reached
//   err                 sticky: host wrote while busy
//   issued_cnt          instructions accepted since last start (saturating)
module instr_sequencer #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic [7:0]  load_addr,
    input  logic [15:0] load_data,
    input  logic        start,
    input  logic [7:0]  start_addr,
    input  logic        abort,
    input  logic        step_mode,
    input  logic        step,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  pc,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [15:0] issued_cnt
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_ISSUE     = 3'd3;
    localparam logic [2:0] S_WAIT_STEP = 3'd4;
    localparam logic [2:0] S_HALT      = 3'd5;

    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_JUMP = 4'hE;

    logic [2:0]  state;
    logic [15:0] mem [DEPTH];
    logic [15:0] rd_data;
    logic        idle_like;
    logic        wr_en;

    assign idle_like = (state == S_IDLE) || (state == S_HALT);
    // abort outranks every other input, including a host write
    assign wr_en     = load_en && idle_like && !abort;

    // Store is not reset. The read runs every cycle from pc; only the value
    // captured at the end of FETCH is consumed (in DECODE). A write landing on
    // the start edge is therefore visible to the first fetch.
    always_ff @(posedge clk) begin
        if (!reset && wr_en)
            mem[load_addr] <= load_data;
        rd_data <= mem[pc];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            instr       <= '0;
            instr_valid <= 1'b0;
            pc          <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
            issued_cnt  <= '0;
        end else if (abort) begin
            // pc, halted, err and issued_cnt deliberately hold
            state       <= S_IDLE;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (load_en && !idle_like)
                err <= 1'b1;
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc         <= start_addr;
                        halted     <= 1'b0;
                        err        <= 1'b0;
                        issued_cnt <= '0;
                        state      <= S_FETCH;
                        busy       <= 1'b1;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    if (rd_data[15:12] == OP_HALT) begin
                        halted <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_HALT;
                    end else if (rd_data[15:12] == OP_JUMP) begin
                        pc    <= rd_data[7:0];
                        state <= S_FETCH;
                    end else begin
                        instr       <= rd_data;
                        instr_valid <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        pc          <= pc + 8'd1;
                        if (issued_cnt != 16'hFFFF)
                            issued_cnt <= issued_cnt + 16'd1;
                        state <= step_mode ? S_WAIT_STEP : S_FETCH;
                    end
                end
                S_WAIT_STEP: begin
                    if (step)
                        state <= S_FETCH;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed timing scenarios plus
// randomized programs checked against a program-interpreting reference model.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset, load_en, start, abort, step_mode, step, instr_ready;
    logic [7:0]  load_addr, start_addr, pc;
    logic [15:0] load_data, instr, issued_cnt;
    logic        instr_valid, busy, halted, err;

    always #5 clk = ~clk;

    instr_sequencer #(.DEPTH(256)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .start_addr(start_addr),
        .abort(abort), .step_mode(step_mode), .step(step), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
        .busy(busy), .halted(halted), .err(err), .issued_cnt(issued_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] model_mem [256];
    logic [15:0] exp_q [$];
    logic [7:0]  exp_pc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [15:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic load_straight();
        load_word(8'h00, 16'h0105);
        load_word(8'h01, 16'h3203);
        load_word(8'h02, 16'hF000);
    endtask

    // Interpret the program: list of words the core should receive and the
    // pc left pointing at the HALT word.
    task automatic model_run(input logic [7:0] sa);
        logic [7:0]  p;
        logic [15:0] w;
        p = sa;
        exp_q.delete();
        for (int i = 0; i < 1024; i++) begin
            w = model_mem[p];
            if (w[15:12] == 4'hF) break;
            else if (w[15:12] == 4'hE) p = w[7:0];
            else begin
                exp_q.push_back(w);
                p = p + 8'd1;
            end
        end
        exp_pc = p;
    endtask

    task automatic run_check(input logic [7:0] sa, input int ready_pct, input string name);
        logic [15:0] got [$];
        logic [15:0] held;
        bit          stalled;
        model_run(sa);
        start = 1'b1; start_addr = sa;
        tick();
        start = 1'b0;
        stalled = 0;
        held = '0;
        for (int c = 0; c < 3000 && !halted; c++) begin
            if (instr_valid) begin
                if (stalled) begin
                    checks++;
                    if (instr !== held) begin
                        errors++;
                        $display("FAIL %s stall_hold: instr %h expected %h", name, instr, held);
                    end
                end
                instr_ready = ($urandom_range(99) < ready_pct);
                if (instr_ready) begin
                    got.push_back(instr);
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = instr;
                end
            end else begin
                instr_ready = 1'($urandom_range(1));
            end
            tick();
        end
        instr_ready = 1'b0;
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL %s halt_timeout: halted %b expected 1", name, halted);
        end
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s count: issued %0d words expected %0d", name, got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s word%0d: got %h expected %h", name, i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (pc !== exp_pc || issued_cnt !== 16'(exp_q.size())) begin
            errors++;
            $display("FAIL %s final: pc %h cnt %0d expected pc %h cnt %0d",
                     name, pc, issued_cnt, exp_pc, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({instr, instr_valid, pc, busy, halted, err, issued_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state: instr %h v %b pc %h busy %b halted %b err %b cnt %h expected all 0",
                     instr, instr_valid, pc, busy, halted, err, issued_cnt);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_straight();
        load_straight();
        instr_ready = 1'b1;
        start = 1'b1; start_addr = 8'h00;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (instr_valid === 1'b1 && instr[15:13] == 3'b111) begin
                errors++;
                $display("FAIL straight_ctl_leak: instr %h in cycle %0d", instr, c);
            end
            if (c == 1) begin
                checks++;
                if (busy !== 1'b1 || instr_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL straight_c1: busy %b v %b expected 1 0", busy, instr_valid);
                end
            end
            if (c == 3 || c == 6) begin
                checks++;
                if (instr_valid !== 1'b1 || instr !== (c == 3 ? 16'h0105 : 16'h3203)) begin
                    errors++;
                    $display("FAIL straight_c%0d: v %b instr %h expected 1 %h", c, instr_valid, instr,
                             (c == 3 ? 16'h0105 : 16'h3203));
                end
            end
            if (c == 4 || c == 8) begin
                checks++;
                if (instr_valid !== 1'b0 || halted !== 1'b0) begin
                    errors++;
                    $display("FAIL straight_c%0d: v %b halted %b expected 0 0", c, instr_valid, halted);
                end
            end
            if (c == 9) begin
                checks++;
                if (halted !== 1'b1 || pc !== 8'h02 || issued_cnt !== 16'd2 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL straight_end: halted %b pc %h cnt %0d busy %b expected 1 02 2 0",
                             halted, pc, issued_cnt, busy);
                end
            end
            if (c < 9) tick();
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        load_straight();
        instr_ready = 1'b0;
        start = 1'b1; start_addr = 8'h00;
        tick();
        start = 1'b0;
        tick(); tick();
        for (int i = 0; i < 6; i++) begin
            // a start pulse while busy must be ignored
            start = (i == 2); start_addr = 8'h02;
            checks++;
            if (instr_valid !== 1'b1 || instr !== 16'h0105 || pc !== 8'h00) begin
                errors++;
                $display("FAIL bp_stall%0d: v %b instr %h pc %h expected 1 0105 00", i, instr_valid, instr, pc);
            end
            tick();
        end
        start = 1'b0;
        instr_ready = 1'b1;
        // the loop above ended on a tick with ready low; this edge accepts
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || pc !== 8'h01 || issued_cnt !== 16'd1) begin
            errors++;
            $display("FAIL bp_accept: v %b pc %h cnt %0d expected 0 01 1", instr_valid, pc, issued_cnt);
        end
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) tick();
        checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h3203 || pc !== 8'h01 || issued_cnt !== 16'd1) begin
            errors++;
            $display("FAIL bp_next: v %b instr %h pc %h cnt %0d expected 1 3203 01 1",
                     instr_valid, instr, pc, issued_cnt);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 20 && halted !== 1'b1; i++) tick();
        instr_ready = 1'b0;
        checks++;
        if (halted !== 1'b1 || issued_cnt !== 16'd2) begin
            errors++;
            $display("FAIL bp_end: halted %b cnt %0d expected 1 2", halted, issued_cnt);
        end
    endtask

    task automatic test_step_mode();
        load_straight();
        step_mode = 1'b1; instr_ready = 1'b1;
        start = 1'b1; start_addr = 8'h00;
        tick();
        start = 1'b0;
        tick(); tick();
        checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h0105) begin
            errors++;
            $display("FAIL step_first: v %b instr %h expected 1 0105", instr_valid, instr);
        end
        tick();
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (busy !== 1'b1 || instr_valid !== 1'b0 || pc !== 8'h01) begin
                errors++;
                $display("FAIL step_wait%0d: busy %b v %b pc %h expected 1 0 01", i, busy, instr_valid, pc);
            end
            tick();
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL step_early: v %b expected 0", instr_valid);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h3203) begin
            errors++;
            $display("FAIL step_plus3: v %b instr %h expected 1 3203", instr_valid, instr);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h3203) begin
            errors++;
            $display("FAIL step_in_issue: v %b instr %h expected 1 3203", instr_valid, instr);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick(); tick(); tick(); tick();
        checks++;
        if (busy !== 1'b1 || instr_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL step_not_latched: busy %b v %b halted %b expected 1 0 0", busy, instr_valid, halted);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        tick(); tick();
        checks++;
        if (halted !== 1'b1 || issued_cnt !== 16'd2 || pc !== 8'h02) begin
            errors++;
            $display("FAIL step_halt: halted %b cnt %0d pc %h expected 1 2 02", halted, issued_cnt, pc);
        end
        step_mode = 1'b0;
    endtask

    task automatic test_illegal_load_abort();
        load_straight();
        instr_ready = 1'b0;
        start = 1'b1; start_addr = 8'h00;
        tick();
        start = 1'b0;
        load_en = 1'b1; load_addr = 8'h01; load_data = 16'hAAAA;
        tick();
        load_en = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_err: err %b expected 1", err);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: v %b expected 1", instr_valid);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b1 || pc !== 8'h00 || halted !== 1'b0) begin
            errors++;
            $display("FAIL abort_post: v %b busy %b err %b pc %h halted %b expected 0 0 1 00 0",
                     instr_valid, busy, err, pc, halted);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy %b expected 0", busy);
        end
        run_check(8'h00, 100, "rerun_after_illegal");
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL rerun_err_clear: err %b expected 0", err);
        end
    endtask

    task automatic test_reset_mid();
        load_straight();
        instr_ready = 1'b1;
        start = 1'b1; start_addr = 8'h01;
        tick();
        start = 1'b0;
        load_en = 1'b1; load_addr = 8'h02; load_data = 16'h5555;
        tick();
        load_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        instr_ready = 1'b0;
        checks++;
        if ({instr, instr_valid, pc, busy, halted, err, issued_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_mid: instr %h v %b pc %h busy %b halted %b err %b cnt %h expected all 0",
                     instr, instr_valid, pc, busy, halted, err, issued_cnt);
        end
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy %b v %b expected 0 0", busy, instr_valid);
        end
        run_check(8'h00, 100, "after_reset");
    endtask

    task automatic test_jump_wrap();
        load_word(8'h10, 16'hE0FF);
        load_word(8'hFF, 16'h0007);
        load_word(8'h00, 16'hF000);
        instr_ready = 1'b1;
        start = 1'b1; start_addr = 8'h10;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (instr_valid === 1'b1 && instr[15:13] == 3'b111) begin
                errors++;
                $display("FAIL jump_ctl_leak: instr %h in cycle %0d", instr, c);
            end
            if (c == 5) begin
                checks++;
                if (instr_valid !== 1'b1 || instr !== 16'h0007 || pc !== 8'hFF) begin
                    errors++;
                    $display("FAIL jump_issue: v %b instr %h pc %h expected 1 0007 ff", instr_valid, instr, pc);
                end
            end
            if (c == 6) begin
                checks++;
                if (pc !== 8'h00 || issued_cnt !== 16'd1) begin
                    errors++;
                    $display("FAIL jump_wrap: pc %h cnt %0d expected 00 1", pc, issued_cnt);
                end
            end
            if (c == 8) begin
                checks++;
                if (halted !== 1'b1 || issued_cnt !== 16'd1 || pc !== 8'h00) begin
                    errors++;
                    $display("FAIL jump_halt: halted %b cnt %0d pc %h expected 1 1 00", halted, issued_cnt, pc);
                end
            end
            if (c < 8) tick();
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_start_load();
        load_word(8'h40, 16'h1111);
        load_word(8'h41, 16'hF123);
        load_en = 1'b1; load_addr = 8'h40; load_data = 16'h2222;
        start = 1'b1; start_addr = 8'h40;
        model_mem[8'h40] = 16'h2222;
        tick();
        load_en = 1'b0; start = 1'b0;
        instr_ready = 1'b1;
        tick(); tick();
        checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h2222) begin
            errors++;
            $display("FAIL start_load: v %b instr %h expected 1 2222", instr_valid, instr);
        end
        for (int i = 0; i < 20 && halted !== 1'b1; i++) tick();
        instr_ready = 1'b0;
        checks++;
        if (halted !== 1'b1 || issued_cnt !== 16'd1 || pc !== 8'h41) begin
            errors++;
            $display("FAIL start_load_end: halted %b cnt %0d pc %h expected 1 1 41", halted, issued_cnt, pc);
        end
    endtask

    task automatic test_random();
        logic [7:0]  b;
        logic [15:0] w;
        int          n, j;
        for (int it = 0; it < 10; it++) begin
            b = 8'($urandom_range(255));
            n = $urandom_range(2, 6);
            j = $urandom_range(0, n - 1);
            for (int i = 0; i < n; i++) begin
                w = 16'($urandom);
                w[15:12] = 4'($urandom_range(13));
                load_word(b + 8'(i), w);
            end
            if ($urandom_range(1) == 1)
                load_word(b + 8'(j), {4'hE, 4'($urandom), 8'(b + 8'(j + 2))});
            load_word(b + 8'(n), {4'hF, 12'($urandom)});
            load_word(b + 8'(n + 1), {4'hF, 12'($urandom)});
            run_check(b, $urandom_range(30, 100), "random");
        end
    endtask

    initial begin
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; start_addr = '0; abort = 1'b0; step_mode = 1'b0;
        step = 1'b0; instr_ready = 1'b0;
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        test_reset();
        test_straight();
        test_backpressure();
        test_step_mode();
        test_illegal_load_abort();
        test_reset_mid();
        test_jump_wrap();
        test_start_load();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction sequencer that feeds the 8-bit CPU core. It holds a 256-word x 16-bit program store that a host loads, then walks it with a program counter and presents one 16-bit instruction at a time on a valid/ready handshake to the core's `instr` input. HALT and JUMP control words are executed here and never forwarded to the core.

## Interface
- `DEPTH`, default 256: program store depth in words. The address width is fixed at 8 bits.
- `clk` in 1: single clock; everything is rising-edge.
- `reset` in 1: synchronous, active-high.
- `load_en` in 1: host write strobe into the program store.
- `load_addr` in 8: host write address.
- `load_data` in 16: host write data.
- `start` in 1: single-cycle pulse that begins execution at `start_addr`.
- `start_addr` in 8: entry point.
- `abort` in 1: return to IDLE from any state.
- `step_mode` in 1: when 1, the sequencer waits for `step` after each accepted instruction.
- `step` in 1: single-cycle advance pulse, used only in step mode.
- `instr` out 16: instruction presented to the core.
- `instr_valid` out 1: `instr` is valid.
- `instr_ready` in 1: the core accepts the instruction.
- `pc` out 8: current program counter.
- `busy` out 1: 1 in FETCH, DECODE, ISSUE and WAIT_STEP.
- `halted` out 1: a HALT word was reached.
- `err` out 1: sticky flag, set when the host writes while busy.
- `issued_cnt` out 16: number of instructions accepted since the last `start`, saturating.

## Operation
- Control words, decoded on `instr[15:12]`:
  - 4'hF is HALT.
  - 4'hE is JUMP; the target is `[7:0]`.
  - Every other word is forwarded unchanged.
- Program store:
  - Synchronous write; synchronous read with 1-cycle latency.
  - Contents are not reset.
  - A write occurs only when `load_en` is high in IDLE or HALT.
  - `load_en` in any other state does not write and sets `err`.
- FSM states are IDLE, FETCH, DECODE, ISSUE, WAIT_STEP and HALT. Transitions:
  - IDLE or HALT, on `start`: `pc <= start_addr`; `halted`, `err` and `issued_cnt` clear; go to FETCH.
  - FETCH: drive the read address `pc`; go to DECODE.
  - DECODE, HALT word: `halted <= 1`; go to HALT; `pc` is unchanged.
  - DECODE, JUMP word: `pc <= [7:0]`; go to FETCH. Nothing is issued and nothing is counted.
  - DECODE, other word: `instr <= word`; `instr_valid <= 1`; go to ISSUE.
  - ISSUE: hold `instr` and `instr_valid` stable until `instr_ready` is high. On the accepting edge:
    - `instr_valid <= 0`;
    - `pc <= pc + 1`, mod 256, so 0xFF wraps to 0x00;
    - `issued_cnt` increments, saturating at 0xFFFF;
    - next state is WAIT_STEP if `step_mode` is set, otherwise FETCH.
  - WAIT_STEP: on `step`, go to FETCH.
- Ignored inputs:
  - `step` outside WAIT_STEP.
  - `start` while busy.
- `abort`:
  - Has priority over all other inputs in every state.
  - Next cycle: state is IDLE and `instr_valid` is 0.
  - `pc`, `halted`, `err` and `issued_cnt` hold their values.
- Reset:
  - Has priority over `abort`, and applies mid-operation as well.
  - Sets `instr` = 0, `instr_valid` = 0, `pc` = 0, `busy` = 0, `halted` = 0, `err` = 0, `issued_cnt` = 0, state = IDLE.
- `start` and `load_en` in the same cycle while in IDLE: the write occurs and execution starts. The first fetch sees the new word if the addresses match, because the write lands on the same edge that the FETCH read follows.

## Timing
- `start` sampled at edge 0: FETCH in cycle 1, DECODE in cycle 2, `instr_valid` high in cycle 3.
- With `instr_ready` tied high: one instruction every 3 cycles.
- Each JUMP adds 2 cycles (FETCH and DECODE).
- `halted` rises 2 cycles after the accepting edge of the preceding instruction.
- `busy`, `halted` and `instr_valid` are all registered; there are no combinational paths from inputs to outputs.
- In step mode, the instruction after the current one is valid 3 cycles after the `step` pulse.

## Test plan
- Straight-line program:
  - Load 0x00=0x0105, 0x01=0x3203, 0x02=0xF000; `start` at 0x00 with `instr_ready` = 1.
  - Required: 0x0105 valid in cycle 3 and 0x3203 valid in cycle 6.
  - Required: `halted` = 1 in cycle 9, `pc` = 0x02, `issued_cnt` = 2, and JUMP/HALT words never appear on `instr`.
- Backpressure:
  - Hold `instr_ready` = 0 for 5 cycles in ISSUE.
  - Required: `instr` and `instr_valid` stable and `pc` unchanged during the stall; on ready, exactly one accept and `pc` + 1.
- Jump and wrap:
  - Load 0x10=0xE0FF, 0xFF=0x0007, 0x00=0xF000; `start` at 0x10.
  - Required: first issued word is 0x0007, `pc` wraps 0xFF to 0x00, then `halted` = 1 and `issued_cnt` = 1.
- Step mode:
  - `step_mode` = 1 with the straight-line program.
  - Required: after the first accept the sequencer sits in WAIT_STEP with `busy` = 1 and `instr_valid` = 0 for 10 cycles.
  - Required: `step` brings 0x3203 valid 3 cycles later.
  - Required: a `step` pulse issued in ISSUE has no effect.
- Illegal load and abort:
  - `load_en` to 0x01 with 0xAAAA while busy.
  - Required: `err` = 1 and 0x01 is unchanged (re-run and observe 0x3203).
  - `abort` during ISSUE. Required: `instr_valid` = 0 and `busy` = 0 on the next cycle.
- Reset mid-run:
  - Assert `reset` in DECODE.
  - Required: next cycle all outputs are 0 and the state is IDLE.
  - Required: a subsequent `start` at 0x00 re-executes from 0x0105, because the store contents survive reset.
